// File: rtl/apple_spawn_module.sv
// Apple placement and eat detection for the snake game: LFSR-driven spawn,
// bonus-apple expiry and the body-grow pulse consumed by score/body logic.
module apple_spawn_module #(
  parameter int unsigned GRID_W      = 40,
  parameter int unsigned GRID_H      = 30,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1,
  parameter int unsigned BONUS_TICKS = 50,
  parameter int unsigned PULSE_LEN   = 4
) (
  input  logic       Clk_50mhz,
  input  logic       Rst_n,
  input  logic [2:0] Game_status,
  input  logic       Move_tick,
  input  logic [5:0] Head_x,
  input  logic [5:0] Head_y,
  output logic [5:0] Apple_x,
  output logic [5:0] Apple_y,
  output logic       Apple_valid,
  output logic       Apple_type,
  output logic       Body_add_sig
);

  localparam int unsigned TW = (BONUS_TICKS > 2) ? $clog2(BONUS_TICKS) : 1;
  localparam int unsigned PW = (PULSE_LEN > 2) ? $clog2(PULSE_LEN) : 1;
  localparam logic [6:0]  GRID_W_L = 7'(GRID_W);
  localparam logic [6:0]  GRID_H_L = 7'(GRID_H);
  localparam logic [2:0]  ST_START = 3'b001;
  localparam logic [2:0]  ST_PLAY  = 3'b010;
  localparam logic [2:0]  ST_END   = 3'b100;

  typedef enum logic [1:0] {IDLE, SPAWN, ACTIVE, EATEN} state_t;

  state_t          state_q, state_d;
  logic [15:0]     lfsr_q;
  logic [5:0]      head_x_q, head_y_q;
  logic [TW-1:0]   tick_cnt_q, tick_cnt_d;
  logic [PW-1:0]   pulse_cnt_q, pulse_cnt_d;
  logic [5:0]      apple_x_q, apple_x_d, apple_y_q, apple_y_d;
  logic            apple_type_q, apple_type_d;
  logic            apple_valid_q, apple_valid_d;
  logic            body_add_q, body_add_d;

  logic [5:0] cand_x, cand_y;
  logic       cand_type, cand_ok, head_hit, lfsr_fb;

  assign lfsr_fb   = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
  assign cand_x    = lfsr_q[5:0];
  assign cand_y    = lfsr_q[11:6];
  assign cand_type = (lfsr_q[15:12] == 4'b0000);
  assign cand_ok   = ({1'b0, cand_x} < GRID_W_L) && ({1'b0, cand_y} < GRID_H_L) &&
                     !((cand_x == head_x_q) && (cand_y == head_y_q));
  assign head_hit  = (Head_x == apple_x_q) && (Head_y == apple_y_q);

  // Next-state and output logic; game-status override applied last so it wins.
  always_comb begin
    state_d       = state_q;
    tick_cnt_d    = tick_cnt_q;
    pulse_cnt_d   = pulse_cnt_q;
    apple_x_d     = apple_x_q;
    apple_y_d     = apple_y_q;
    apple_type_d  = apple_type_q;
    apple_valid_d = apple_valid_q;
    body_add_d    = body_add_q;

    case (state_q)
      IDLE: begin
        apple_valid_d = 1'b0;
        if (Game_status == ST_PLAY) state_d = SPAWN;
      end
      SPAWN: begin
        if (cand_ok) begin
          apple_x_d     = cand_x;
          apple_y_d     = cand_y;
          apple_type_d  = cand_type;
          apple_valid_d = 1'b1;
          tick_cnt_d    = '0;
          state_d       = ACTIVE;
        end
      end
      ACTIVE: begin
        if (Move_tick) begin
          if (head_hit) begin
            apple_valid_d = 1'b0;
            body_add_d    = 1'b1;
            pulse_cnt_d   = PW'(PULSE_LEN - 1);
            state_d       = EATEN;
          end else if (apple_type_q) begin
            if (tick_cnt_q == TW'(BONUS_TICKS - 1)) begin
              apple_valid_d = 1'b0;
              state_d       = SPAWN;
            end else begin
              tick_cnt_d = tick_cnt_q + TW'(1);
            end
          end
        end
      end
      EATEN: begin
        if (pulse_cnt_q == '0) begin
          body_add_d = 1'b0;
          state_d    = SPAWN;
        end else begin
          pulse_cnt_d = pulse_cnt_q - PW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if ((Game_status == ST_END) || (Game_status == ST_START)) begin
      state_d       = IDLE;
      apple_valid_d = 1'b0;
      body_add_d    = 1'b0;
      tick_cnt_d    = '0;
      pulse_cnt_d   = '0;
    end
  end

  always_ff @(posedge Clk_50mhz or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q       <= IDLE;
      lfsr_q        <= LFSR_SEED;
      head_x_q      <= '0;
      head_y_q      <= '0;
      tick_cnt_q    <= '0;
      pulse_cnt_q   <= '0;
      apple_x_q     <= '0;
      apple_y_q     <= '0;
      apple_type_q  <= 1'b0;
      apple_valid_q <= 1'b0;
      body_add_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      lfsr_q        <= {lfsr_q[14:0], lfsr_fb};
      tick_cnt_q    <= tick_cnt_d;
      pulse_cnt_q   <= pulse_cnt_d;
      apple_x_q     <= apple_x_d;
      apple_y_q     <= apple_y_d;
      apple_type_q  <= apple_type_d;
      apple_valid_q <= apple_valid_d;
      body_add_q    <= body_add_d;
      // Head position is latched on every step regardless of state.
      if (Move_tick) begin
        head_x_q <= Head_x;
        head_y_q <= Head_y;
      end
    end
  end

  assign Apple_x      = apple_x_q;
  assign Apple_y      = apple_y_q;
  assign Apple_type   = apple_type_q;
  assign Apple_valid  = apple_valid_q;
  assign Body_add_sig = body_add_q;

endmodule

// File: doc/apple_spawn_module.md
Name: apple_spawn_module

Overview:
- Upstream stage of the score display.
- Places the apple on the play grid using a free-running LFSR.
- Detects when the snake head lands on the apple and emits the body-grow pulse and the apple type that the score display and body logic consume.
- Supports a bonus apple (type 1, worth 2 points downstream) that expires after a fixed number of move ticks.

Parameters:
- GRID_W, 40, grid columns; valid x is 0..GRID_W-1, GRID_W ≤ 64.
- GRID_H, 30, grid rows; valid y is 0..GRID_H-1, GRID_H ≤ 64.
- LFSR_SEED, 16'hACE1, LFSR reset value; must be nonzero.
- BONUS_TICKS, 50, number of move ticks a bonus apple stays before expiring.
- PULSE_LEN, 4, clock cycles Body_add_sig is held high per eat; must be ≥ 1.

Ports:
- Clk_50mhz  input  1  50 MHz system clock.
- Rst_n  input  1  reset, asynchronous, active-low.
- Game_status  input  3  one-hot game state: START 001, PLAY 010, END 100.
- Move_tick  input  1  one-cycle pulse on each snake step.
- Head_x  input  6  snake head column, valid when Move_tick is high.
- Head_y  input  6  snake head row, valid when Move_tick is high.
- Apple_x  output  6  current apple column.
- Apple_y  output  6  current apple row.
- Apple_valid  output  1  apple is placed and drawable.
- Apple_type  output  1  0 = normal, 1 = bonus; stable while Body_add_sig is high.
- Body_add_sig  output  1  grow/score pulse, high for PULSE_LEN cycles.

Behaviour:
- Reset values:
  - All outputs are 0.
  - lfsr = LFSR_SEED, state = IDLE, tick counter = 0, pulse counter = 0.
- LFSR:
  - 16-bit Fibonacci, advances every clock in every state, including IDLE.
  - fb = l[15]^l[13]^l[12]^l[10]; l <= {l[14:0], fb}.
- Candidate, taken from the current LFSR value each cycle:
  - cx = l[5:0], cy = l[11:6], ctype = (l[15:12] == 4'b0000).
- States:
  - IDLE: Apple_valid = 0. Go to SPAWN when Game_status == PLAY.
  - SPAWN: accept the candidate if cx < GRID_W, cy < GRID_H, and (cx,cy) ≠ (latched head x, latched head y).
    - On accept: load Apple_x = cx, Apple_y = cy, Apple_type = ctype; set Apple_valid = 1; clear the tick counter; go to ACTIVE.
    - On reject: stay in SPAWN and retry with the next LFSR value on the next cycle.
  - ACTIVE, evaluated on each Move_tick:
    - If Head_x == Apple_x and Head_y == Apple_y: Apple_valid = 0, Body_add_sig = 1, pulse counter = PULSE_LEN-1, go to EATEN.
    - Otherwise, if Apple_type == 1, increment the tick counter. When it reaches BONUS_TICKS-1 on a tick: Apple_valid = 0, go to SPAWN. No pulse is issued.
  - EATEN: Body_add_sig stays high and the pulse counter decrements each cycle. When the counter is 0: Body_add_sig = 0, go to SPAWN. Apple_type holds its value through the whole pulse.
- Head latch:
  - Head_x/Head_y are registered on every Move_tick.
  - SPAWN excludes the latched head position.
- Simultaneous events:
  - Eat and bonus expiry on the same tick: eat wins, Body_add_sig fires with Apple_type = 1.
- Game_status overrides, taking priority over everything else in all states:
  - Game_status == END or START: next cycle state = IDLE, Apple_valid = 0, Body_add_sig = 0, counters = 0.
  - This applies even mid-pulse.
  - The LFSR is not reseeded.
  - Apple_x, Apple_y and Apple_type hold their last values.
- Latency: eat is detected on the Move_tick cycle; Body_add_sig rises on the next clock edge.
- Move_tick in SPAWN or EATEN: ignored, except for head latching.
- Rst_n asserted at any time: immediate return to reset values.

Test Plan:
- Reset, then Game_status = PLAY with head at (0,0):
  - From 16'hACE1, the first LFSR values are checked against a reference model.
  - Apple_valid rises on the first in-range candidate.
  - Apple_x < 40, Apple_y < 30, and the position is not (0,0).
- Normal apple placed at (x,y), drive Move_tick with Head = (x,y):
  - Body_add_sig is high for exactly 4 cycles starting the cycle after the tick.
  - Apple_type = 0 throughout the pulse.
  - Apple_valid drops, then a new apple spawns.
- Force a bonus apple (ctype = 1) with the head never matching; drive 50 Move_ticks:
  - Apple_valid drops after the 50th tick.
  - No Body_add_sig pulse.
  - Respawn follows.
- Bonus apple, eat on the 50th tick:
  - Body_add_sig fires for 4 cycles with Apple_type = 1.
  - No expiry action.
- Game_status = END two cycles into a pulse:
  - Body_add_sig = 0 and Apple_valid = 0 on the next cycle; state is IDLE.
  - Returning to PLAY respawns the apple.
- Assert Rst_n low mid-SPAWN:
  - All outputs are 0 immediately (asynchronous).
  - The LFSR sequence restarts from 16'hACE1.
